noc_local_injector: RTL and testbench

//  Packet source for one router's LOCAL port: takes a packet request (target, size) plus a payload word stream

---
 rtl/noc_local_injector_pkg.sv | 26 ++
 rtl/noc_flit_fifo.sv | 69 ++++++
 rtl/noc_local_injector.sv | 160 ++++++++++++++++
 tb/tb_noc_local_injector.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_local_injector_pkg.sv
// ============================================================================
// Module      : noc_local_injector_pkg
// Description : Shared flit geometry, local port index and injector FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package noc_local_injector_pkg;

  localparam int c_tam_flit    = 16;
  localparam int c_metadeflit  = 8;
  localparam int c_fifo_depth  = 16;
  localparam logic [2:0] c_local_port = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_SIZE    = 2'd2,
    ST_PAYLOAD = 2'd3
  } inj_state_e;

endpackage : noc_local_injector_pkg

`default_nettype wire

// File: rtl/noc_flit_fifo.sv
// ============================================================================
// Module      : noc_flit_fifo
// Description : Synchronous power-of-two FIFO with occupancy count; a push
//               is refused whenever the FIFO is full, even if a pop happens
//               in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module noc_flit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
  localparam logic [c_cw-1:0] c_cnt_depth = c_cw'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign full      = (r_count == c_cnt_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so wrap-around is free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_en) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : noc_flit_fifo

`default_nettype wire

// File: rtl/noc_local_injector.sv
// ============================================================================
// Module      : noc_local_injector
// Description : Serialises PE packet requests plus a buffered payload stream
//               into header/size/payload flits on a router local port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module noc_local_injector
  import noc_local_injector_pkg::*;
#(
  parameter int TAM_FLIT   = c_tam_flit,
  parameter int METADEFLIT = c_metadeflit,
  parameter int FIFO_DEPTH = c_fifo_depth
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TAM_FLIT-1:0] req_target,
  input  logic [TAM_FLIT-1:0] req_size,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [TAM_FLIT-1:0] pl_data,
  output logic                flit_tx,
  output logic [TAM_FLIT-1:0] flit_data,
  input  logic                credit_in,
  output logic                busy,
  output logic                pkt_done
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w-1:0]  c_fifo_full_cnt = c_cnt_w'(FIFO_DEPTH);
  localparam logic [TAM_FLIT-1:0] c_rem_one       = TAM_FLIT'(1);

  inj_state_e          r_state;
  logic [TAM_FLIT-1:0] r_target;
  logic [TAM_FLIT-1:0] r_size;
  logic [TAM_FLIT-1:0] r_remaining;
  logic                r_pkt_done;

  logic [TAM_FLIT-1:0] w_header;
  logic [TAM_FLIT-1:0] w_fifo_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [c_cnt_w-1:0]  w_fifo_count;
  logic                w_fifo_push;
  logic                w_fifo_pop;
  logic                w_flit_tx;
  logic [TAM_FLIT-1:0] w_flit_data;
  logic                w_flit_acc;

  // Header carries only the {X,Y} coordinates, zero-extended to a flit.
  if (2*METADEFLIT < TAM_FLIT) begin : g_hdr_pad
    assign w_header = {{(TAM_FLIT-2*METADEFLIT){1'b0}}, req_target[2*METADEFLIT-1:0]};
  end else begin : g_hdr_full
    assign w_header = req_target;
  end

  assign w_fifo_push = pl_valid && !w_fifo_full;
  assign w_fifo_pop  = (r_state == ST_PAYLOAD) && w_flit_acc;

  noc_flit_fifo #(
    .WIDTH (TAM_FLIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_fifo_push),
    .push_data (pl_data),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  // Flit mux is decoded from registered state only, so a stalled flit
  // cannot change until the router returns a credit.
  always_comb begin
    w_flit_tx   = 1'b0;
    w_flit_data = '0;
    case (r_state)
      ST_HEADER: begin
        w_flit_tx   = 1'b1;
        w_flit_data = r_target;
      end
      ST_SIZE: begin
        w_flit_tx   = 1'b1;
        w_flit_data = r_size;
      end
      ST_PAYLOAD: begin
        w_flit_tx   = !w_fifo_empty;
        w_flit_data = w_fifo_empty ? '0 : w_fifo_head;
      end
      default: begin
        w_flit_tx   = 1'b0;
        w_flit_data = '0;
      end
    endcase
  end

  assign w_flit_acc = w_flit_tx && credit_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_size      <= '0;
      r_remaining <= '0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_target    <= w_header;
            r_size      <= req_size;
            r_remaining <= req_size;
            r_state     <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (credit_in) r_state <= ST_SIZE;
        end
        ST_SIZE: begin
          if (credit_in) begin
            if (r_size == '0) begin
              r_state    <= ST_IDLE;
              r_pkt_done <= 1'b1;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_flit_acc) begin
            if (r_remaining != '0) r_remaining <= r_remaining - c_rem_one;
            if (r_remaining <= c_rem_one) begin
              r_state    <= ST_IDLE;
              r_pkt_done <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign pkt_done  = r_pkt_done;
  assign pl_ready  = (w_fifo_count != c_fifo_full_cnt);
  assign flit_tx   = w_flit_tx;
  assign flit_data = w_flit_data;

endmodule : noc_local_injector

`default_nettype wire

// File: tb/tb_noc_local_injector.sv
// ============================================================================
// Module      : tb_noc_local_injector
// Description : Scoreboard bench: packets are modelled as header, size and
//               the next N words of the payload stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_noc_local_injector;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int BOUND = 3000;
  localparam int K_HDR  = 0;
  localparam int K_SIZE = 1;
  localparam int K_PAY  = 2;

  typedef struct {
    int         kind;
    logic [W-1:0] val;
    bit         last;
  } tok_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_target;
  logic [W-1:0] req_size;
  logic         pl_valid;
  logic         pl_ready;
  logic [W-1:0] pl_data;
  logic         flit_tx;
  logic [W-1:0] flit_data;
  logic         credit_in;
  logic         busy;
  logic         pkt_done;

  logic [1:0]   credit_mode;
  logic         rnd_credit;
  bit           pl_gap;

  int n_checks = 0;
  int n_fail   = 0;

  tok_t         exp_q[$];
  logic [W-1:0] pl_q[$];
  logic [W-1:0] feed_q[$];
  bit           exp_done;
  bit           prev_stall;
  logic [W-1:0] prev_data;

  always #5 clock = ~clock;

  assign credit_in = (credit_mode == 2'd2) ? rnd_credit : credit_mode[0];

  noc_local_injector #(
    .TAM_FLIT   (W),
    .METADEFLIT (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_size   (req_size),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .flit_tx    (flit_tx),
    .flit_data  (flit_data),
    .credit_in  (credit_in),
    .busy       (busy),
    .pkt_done   (pkt_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [W-1:0] tgt, input logic [W-1:0] sz);
    req_valid  = 1'b1;
    req_target = tgt;
    req_size   = sz;
    for (int i = 0; i < BOUND; i++) begin
      if (req_ready) begin
        step();
        req_valid = 1'b0;
        return;
      end
      step();
    end
    req_valid = 1'b0;
    timeout_fail("send_req");
  endtask

  task automatic wait_done();
    for (int i = 0; i < BOUND; i++) begin
      if (!busy) return;
      step();
    end
    timeout_fail("wait_done");
  endtask

  task automatic wait_feed();
    for (int i = 0; i < BOUND; i++) begin
      if (feed_q.size() == 0) begin
        step();
        return;
      end
      step();
    end
    timeout_fail("wait_feed");
  endtask

  // Payload feeder: presents feed_q words in order, optionally with gaps.
  initial begin
    bit acc;
    pl_valid = 1'b0;
    pl_data  = '0;
    forever begin
      @(negedge clock);
      acc = pl_valid && pl_ready && reset;
      @(posedge clock);
      #1;
      if (acc && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && !(pl_gap && $urandom_range(0, 3) == 0)) begin
        pl_valid = 1'b1;
        pl_data  = feed_q[0];
      end else begin
        pl_valid = 1'b0;
      end
    end
  end

  initial begin
    rnd_credit = 1'b1;
    forever begin
      @(posedge clock);
      rnd_credit <= ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares DUT against the packet-level model just before each edge.
  always @(negedge clock) begin : p_mon
    tok_t         t;
    bit           idle_m;
    bit           full_m;
    bit           exp_tx;
    logic [W-1:0] v;
    int           n;
    if (!reset) begin
      exp_q.delete();
      pl_q.delete();
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      idle_m = (exp_q.size() == 0);
      full_m = (pl_q.size() >= DEPTH);
      chk("pkt_done", {31'd0, pkt_done}, {31'd0, exp_done});
      chk("busy", {31'd0, busy}, {31'd0, !idle_m});
      chk("req_ready", {31'd0, req_ready}, {31'd0, idle_m});
      chk("pl_ready", {31'd0, pl_ready}, {31'd0, !full_m});
      if (idle_m)                      exp_tx = 1'b0;
      else if (exp_q[0].kind != K_PAY) exp_tx = 1'b1;
      else                             exp_tx = (pl_q.size() > 0);
      chk("flit_tx", {31'd0, flit_tx}, {31'd0, exp_tx});
      if (prev_stall) begin
        chk("stall_tx_hold", {31'd0, flit_tx}, 32'd1);
        chk("stall_data_hold", {16'd0, flit_data}, {16'd0, prev_data});
      end
      exp_done = 1'b0;
      if (flit_tx && credit_in) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_flit");
        end else begin
          t = exp_q.pop_front();
          if (t.kind == K_PAY) begin
            if (pl_q.size() > 0) v = pl_q.pop_front();
            else v = 'x;
          end else begin
            v = t.val;
          end
          chk("flit_data", {16'd0, flit_data}, {16'd0, v});
          exp_done = t.last;
        end
      end
      prev_stall = flit_tx && !credit_in;
      prev_data  = flit_data;
      if (pl_valid && !full_m) pl_q.push_back(pl_data);
      if (req_valid && idle_m) begin
        n = int'(req_size);
        exp_q.push_back('{K_HDR, req_target, 1'b0});
        exp_q.push_back('{K_SIZE, req_size, (n == 0)});
        for (int i = 0; i < n; i++) exp_q.push_back('{K_PAY, '0, (i == n - 1)});
      end
    end
  end

  initial begin
    #900000;
    timeout_fail("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [W-1:0] sz;
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_target  = '0;
    req_size    = '0;
    credit_mode = 2'd1;
    pl_gap      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_pl_ready", {31'd0, pl_ready}, 32'd1);
    chk("rst_flit_tx", {31'd0, flit_tx}, 32'd0);
    chk("rst_flit_data", {16'd0, flit_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    @(posedge clock);
    #3 reset = 1'b1;
    step();

    // Basic back-to-back packet
    feed_q.push_back(16'h00A1);
    feed_q.push_back(16'h00A2);
    feed_q.push_back(16'h00A3);
    wait_feed();
    send_req(16'h0102, 16'd3);
    for (int k = 0; k < 5; k++) begin
      chk("basic_b2b_tx", {31'd0, flit_tx}, 32'd1);
      step();
    end
    chk("basic_done", {31'd0, pkt_done}, 32'd1);
    chk("basic_idle", {31'd0, busy}, 32'd0);

    // Backpressure held on the size flit
    feed_q.push_back(16'h00B1);
    feed_q.push_back(16'h00B2);
    feed_q.push_back(16'h00B3);
    wait_feed();
    send_req(16'h0304, 16'd3);
    step();
    credit_mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_tx", {31'd0, flit_tx}, 32'd1);
      chk("bp_data", {16'd0, flit_data}, 32'h0003);
      step();
    end
    credit_mode = 2'd1;
    wait_done();

    // Zero-size packet leaves a queued word for the next packet
    feed_q.push_back(16'h00C1);
    wait_feed();
    send_req(16'h0506, 16'd0);
    chk("zero_hdr", {16'd0, flit_data}, 32'h0506);
    step();
    chk("zero_size", {16'd0, flit_data}, 32'h0000);
    step();
    chk("zero_done", {31'd0, pkt_done}, 32'd1);
    chk("zero_ready", {31'd0, req_ready}, 32'd1);
    send_req(16'h0708, 16'd1);
    wait_done();

    // Fill the FIFO, then two 10-flit packets across the pointer wrap
    for (int k = 0; k < 20; k++) feed_q.push_back(16'h1000 + 16'(k));
    repeat (18) step();
    chk("fifo_full_ready", {31'd0, pl_ready}, 32'd0);
    send_req(16'h0A0B, 16'd10);
    wait_done();
    send_req(16'h0C0D, 16'd10);
    wait_done();

    // Underrun bubble
    feed_q.push_back(16'h00D1);
    feed_q.push_back(16'h00D2);
    wait_feed();
    send_req(16'h0E0F, 16'd4);
    repeat (4) step();
    chk("underrun_bubble", {31'd0, flit_tx}, 32'd0);
    step();
    chk("underrun_bubble2", {31'd0, flit_tx}, 32'd0);
    feed_q.push_back(16'h00D3);
    feed_q.push_back(16'h00D4);
    wait_done();

    // Asynchronous reset while a payload flit is on the link
    for (int k = 0; k < 6; k++) feed_q.push_back(16'h2000 + 16'(k));
    wait_feed();
    send_req(16'h1112, 16'd6);
    step();
    step();
    credit_mode = 2'd0;
    chk("pre_reset_tx", {31'd0, flit_tx}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, flit_tx}, 32'd0);
    chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    feed_q.delete();
    credit_mode = 2'd1;
    @(posedge clock);
    #3 reset = 1'b1;
    step();
    chk("reset_fifo_empty", {31'd0, pl_ready}, 32'd1);
    repeat (3) step();

    // Randomised traffic with payload gaps and credit stalls
    credit_mode = 2'd2;
    pl_gap      = 1'b1;
    for (int p = 0; p < 40; p++) begin
      sz = W'($urandom_range(0, 12));
      for (int k = 0; k < int'(sz); k++) feed_q.push_back(W'($urandom));
      send_req(W'($urandom), sz);
    end
    for (int i = 0; i < BOUND; i++) begin
      if (!busy && feed_q.size() == 0) break;
      step();
    end
    credit_mode = 2'd1;
    repeat (4) step();
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_flits", exp_q.size(), 32'd0);
    chk("drain_payload", pl_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_noc_local_injector

`default_nettype wire
